serial_sub: RTL and testbench

- Bit-serial subtractor, LSB-first. Computes DIFF = A - B - Bin over WIDTH clock cycles using one full-subtractor slice and a registered borrow.
- Inverse datapath companion to the team's full-adder cell; used in area-constrained arithmetic paths where one-bit-per-cycle throughput is acceptable.
- Start/busy/done handshake; result held until the next operation.

---
 rtl/serial_sub.sv | 120 ++++++++++++
 tb/tb_serial_sub.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// serial_sub: LSB-first bit-serial subtractor.
// Computes diff = a - b - bin (mod 2^WIDTH) one bit per clock with a single
// full-subtractor slice and a registered borrow. Start/busy/done handshake;
// the result is held until the next operation completes.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Counter only needs to reach WIDTH-1; WIDTH >= 2 keeps CW >= 1.
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One full-subtractor slice: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
    logic d;
    logic bo;
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
    return {bo, d};
  endfunction

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             br_d;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       slice_s;

  // Subtractor slice on the current operand LSBs and the next result shift value.
  always_comb begin
    slice_s = full_sub(a_q[0], b_q[0], br_q);
    br_d    = slice_s[1];
    res_d   = {slice_s[0], res_q[WIDTH-1:1]};
  end

  // Control FSM, operand/result shifting and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        // IDLE and DONE accept a new start identically (back-to-back ops).
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub (WIDTH=8) with directed, hand-computed vectors.
module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int done_cnt = 0;

  // Expected {bout, diff} per accepted operation, in order.
  logic [8:0] exp_q[$];

  serial_sub #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation and compares.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      logic [8:0] e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("diff", {24'd0, diff}, {24'd0, e[7:0]});
        check("bout", {31'd0, bout}, {31'd0, e[8]});
      end
    end
  end

  // Called #1 after the accepting edge; counts edges until done and busy cycles.
  task automatic wait_done(output int edges, output int busy_cyc);
    edges    = 0;
    busy_cyc = (busy === 1'b1) ? 1 : 0;
    while (edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
      if (done === 1'b1) break;
      if (busy === 1'b1) busy_cyc++;
    end
    if (edges >= 50) check("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input logic [7:0] ed, input logic eb, input string tag);
    int edges;
    int bc;
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    exp_q.push_back({eb, ed});
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(edges, bc);
    check({tag, "_latency"}, edges, 32'd8);
    check({tag, "_busy_cycles"}, bc, 32'd8);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    int bc;
    int dc;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, "op35_12");
    do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "op00_01");
    do_op(8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, "opAA_AA");
    do_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "op10_0F_b");
    do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "op00_00_b");

    // Busy rejection: start held with different operands while running.
    @(negedge clk);
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 8'h7F});
    @(posedge clk);
    #1 a = 8'hFF; b = 8'hFF;
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    wait_done(edges, bc);
    check("reject_latency", edges, 32'd4);
    @(posedge clk);
    #1;
    check("reject_no_restart_busy", {31'd0, busy}, 32'd0);

    // Back-to-back: start held; operands swap in the DONE cycle.
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b1, 8'hFE});
    @(posedge clk);
    #1;
    wait_done(edges, bc);
    check("b2b_first_latency", edges, 32'd8);
    a = 8'h03; b = 8'h05;
    @(posedge clk);
    #1;
    check("b2b_accept_in_done", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done(edges, bc);
    check("b2b_second_gap", edges + 1, 32'd9);
    @(posedge clk);
    #1;

    // Reset mid-operation after three RUN edges.
    @(negedge clk);
    a = 8'h99; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_diff", {24'd0, diff}, 32'd0);
    check("midrst_bout", {31'd0, bout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_cnt - dc, 32'd0);

    do_op(8'h44, 8'h04, 1'b0, 8'h40, 1'b0, "op44_04");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
